// File: rtl/i2s_pkg.sv
// Shared types for the I2S receiver control plane.
// Controller states and the receiver channel configuration bundle.
package i2s_pkg;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      SYNC     = 2'd1,
      RUN      = 2'd2,
      DRAIN    = 2'd3
   } ctrl_state_t;

   localparam logic LEFT  = 1'b0;
   localparam logic RIGHT = 1'b1;

   typedef struct packed {
      logic en;
      logic single;
      logic sel;
   } cfg_t;

endpackage

// File: rtl/i2s_ws_monitor.sv
// WS edge detector and loss-of-lock watchdog.
// Reports frame starts and a one-cycle timeout when WS stops toggling.
module i2s_ws_monitor #(
   parameter int WS_TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ws_i,
   output logic fall,
   output logic timeout
);

   localparam int CW = $clog2(WS_TIMEOUT);
   localparam logic [CW-1:0] CMAX = CW'(WS_TIMEOUT - 1);

   logic          ws_q;
   logic          ws_edge;
   logic [CW-1:0] cnt;

   assign ws_edge = ws_q ^ ws_i;
   assign fall    = ws_q & ~ws_i;
   // an edge in the terminal cycle wins over the timeout
   assign timeout = active & ~ws_edge & (cnt == CMAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ws_q <= 1'b0;
      end else begin
         ws_q <= ws_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!active || ws_edge || timeout) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// Run-time controller for the I2S receiver.
// Applies enable/channel commands at frame boundaries after drain.
module i2s_rx_ctrl
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH  = 24,
   parameter int SYNC_FRAMES = 2,
   parameter int WS_TIMEOUT  = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_en,
   input  logic        cmd_single,
   input  logic        cmd_sel,
   input  logic        ws_i,
   input  logic        rx_tx_valid,
   input  logic        rx_tx_ready,
   output logic        rx_en,
   output logic        rx_cfg_single,
   output logic        rx_cfg_sel,
   output logic        locked,
   output logic        ws_lost,
   output logic [15:0] frame_cnt
);

   if (DATA_WIDTH < 1 || SYNC_FRAMES < 1 || WS_TIMEOUT < 4) begin : g_param_check
      $error("i2s_rx_ctrl: illegal parameter value");
   end

   localparam int SW = $clog2(SYNC_FRAMES + 1);
   localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_FRAMES - 1);

   ctrl_state_t   state_q, state_d;
   cfg_t          pend_q, pend_d;
   logic          single_q, single_d;
   logic          sel_q, sel_d;
   logic [SW-1:0] sync_q, sync_d;
   logic [15:0]   frame_q, frame_d;
   logic          seen_q, seen_d;
   logic          lost_q;
   logic          fall;
   logic          timeout;
   logic          drained;
   logic          active;

   assign active = (state_q != DISABLED);

   i2s_ws_monitor #(
      .WS_TIMEOUT(WS_TIMEOUT)
   ) u_ws_monitor (
      .clk     (clk),
      .rst     (rst),
      .active  (active),
      .ws_i    (ws_i),
      .fall    (fall),
      .timeout (timeout)
   );

   // the word in flight is gone, or leaves this cycle
   assign drained = ~rx_tx_valid | rx_tx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DISABLED;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      single_d  = single_q;
      sel_d     = sel_q;
      sync_d    = sync_q;
      frame_d   = frame_q;
      seen_d    = seen_q;
      cmd_ready = 1'b0;
      unique case (state_q)
         DISABLED: begin
            cmd_ready = 1'b1;
            if (cmd_valid && cmd_en) begin
               single_d = cmd_single;
               sel_d    = cmd_sel;
               frame_d  = '0;
               sync_d   = '0;
               state_d  = SYNC;
            end
         end
         SYNC: begin
            if (timeout) begin
               sync_d = '0;
            end else if (fall) begin
               sync_d = sync_q + 1'b1;
               if (sync_q == SYNC_LAST) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            cmd_ready = ~timeout;
            if (fall) begin
               frame_d = frame_q + 16'd1;
            end
            if (timeout) begin
               sync_d  = '0;
               state_d = SYNC;
            end else if (cmd_valid) begin
               pend_d  = '{en: cmd_en, single: cmd_single, sel: cmd_sel};
               seen_d  = 1'b0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (fall) begin
               frame_d = frame_q + 16'd1;
               seen_d  = 1'b1;
            end
            if (timeout || ((seen_q || fall) && drained)) begin
               if (pend_q.en) begin
                  single_d = pend_q.single;
                  sel_d    = pend_q.sel;
                  sync_d   = '0;
                  state_d  = SYNC;
               end else begin
                  state_d  = DISABLED;
               end
            end
         end
         default: begin
            state_d = DISABLED;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q   <= '0;
         single_q <= 1'b0;
         sel_q    <= LEFT;
         sync_q   <= '0;
         frame_q  <= '0;
         seen_q   <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         single_q <= single_d;
         sel_q    <= sel_d;
         sync_q   <= sync_d;
         frame_q  <= frame_d;
         seen_q   <= seen_d;
         lost_q   <= timeout;
      end
   end

   assign rx_en         = (state_q == RUN) || (state_q == DRAIN);
   assign locked        = (state_q == RUN);
   assign rx_cfg_single = single_q;
   assign rx_cfg_sel    = sel_q;
   assign ws_lost       = lost_q;
   assign frame_cnt     = frame_q;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Self-checking bench for i2s_rx_ctrl.
// Config scoreboard plus table of run-time commands and corner sequences.
module tb_i2s_rx_ctrl;
   import i2s_pkg::*;

   localparam int SF = 2;
   localparam int WT = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_en = 1'b0;
   logic        cmd_single = 1'b0;
   logic        cmd_sel = 1'b0;
   logic        ws_i = 1'b0;
   logic        rx_tx_valid = 1'b0;
   logic        rx_tx_ready = 1'b0;
   logic        cmd_ready;
   logic        rx_en;
   logic        rx_cfg_single;
   logic        rx_cfg_sel;
   logic        locked;
   logic        ws_lost;
   logic [15:0] frame_cnt;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   ws_falls = 0;
   int   last_edge = 0;
   int   ws_ctr = 0;
   bit   ws_run = 1'b0;
   logic [1:0] sb_q[$];
   logic locked_prev = 1'b0;

   typedef struct {
      logic  en;
      logic  single;
      logic  sel;
      logic  exp_ready;
      logic  exp_single;
      logic  exp_sel;
      string nm;
   } vec_t;

   vec_t tv[4];

   i2s_rx_ctrl #(
      .DATA_WIDTH  (24),
      .SYNC_FRAMES (SF),
      .WS_TIMEOUT  (WT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_en        (cmd_en),
      .cmd_single    (cmd_single),
      .cmd_sel       (cmd_sel),
      .ws_i          (ws_i),
      .rx_tx_valid   (rx_tx_valid),
      .rx_tx_ready   (rx_tx_ready),
      .rx_en         (rx_en),
      .rx_cfg_single (rx_cfg_single),
      .rx_cfg_sel    (rx_cfg_sel),
      .locked        (locked),
      .ws_lost       (ws_lost),
      .frame_cnt     (frame_cnt)
   );

   always #5 clk = ~clk;

   // WS toggles every 24 cycles while ws_run is set
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (ws_run) begin
            if (ws_ctr == 23) begin
               ws_ctr = 0;
               if (ws_i) ws_falls++;
               ws_i = ~ws_i;
               last_edge = cyc;
            end else begin
               ws_ctr++;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // scoreboard: push on accepted enable command, pop when lock is gained
   initial begin
      logic [1:0] e;
      forever begin
         @(negedge clk);
         if (locked && !locked_prev && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_cfg", {30'd0, rx_cfg_single, rx_cfg_sel}, {30'd0, e});
         end
         if (!rst && cmd_valid && cmd_ready && cmd_en)
            sb_q.push_back({cmd_single, cmd_sel});
         locked_prev = locked;
      end
   end

   task automatic chk_reset(input string nm);
      chk({nm, "_rx_en"}, rx_en, 0);
      chk({nm, "_single"}, rx_cfg_single, 0);
      chk({nm, "_sel"}, rx_cfg_sel, 0);
      chk({nm, "_locked"}, locked, 0);
      chk({nm, "_ws_lost"}, ws_lost, 0);
      chk({nm, "_frame"}, frame_cnt, 0);
      chk({nm, "_ready"}, cmd_ready, 1);
   endtask

   task automatic send_cmd(input logic en, input logic single,
                           input logic sel, output int f0);
      bit ok = 0;
      f0 = ws_falls;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_en = en;
      cmd_single = single;
      cmd_sel = sel;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            f0 = ws_falls;
         end
         @(posedge clk);
      end
      #1;
      cmd_valid = 1'b0;
      chk("cmd_accept", ok, 1);
   endtask

   task automatic wait_en_low(output int f0, output bit ok);
      int prev = ws_falls;
      ok = 0;
      f0 = ws_falls;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (!rx_en) begin
            ok = 1;
            f0 = prev;
         end
         prev = ws_falls;
      end
   endtask

   task automatic wait_lock(input int f0, input string nm);
      bit ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (ws_falls >= f0 + SF) ok = 1;
      end
      chk({nm, "_reach"}, ok, 1);
      if (ok) begin
         chk({nm, "_hold"}, rx_en, 0);
         @(negedge clk);
         chk({nm, "_en"}, rx_en, 1);
         chk({nm, "_locked"}, locked, 1);
      end
   endtask

   task automatic wait_fall_cnt(input logic [15:0] exp, input string nm);
      int f = ws_falls;
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (ws_falls > f) ok = 1;
      end
      @(negedge clk);
      chk(nm, ok ? {16'd0, frame_cnt} : 32'hdead, {16'd0, exp});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int f0, f1, le;
      bit ok, hold;
      logic [15:0] fc;

      tv[0] = '{1'b1, 1'b1, LEFT,  1'b0, 1'b1, LEFT,  "tv_single_l"};
      tv[1] = '{1'b1, 1'b0, RIGHT, 1'b0, 1'b0, RIGHT, "tv_stereo_r"};
      tv[2] = '{1'b1, 1'b0, LEFT,  1'b0, 1'b0, LEFT,  "tv_stereo_l"};
      tv[3] = '{1'b0, 1'b1, RIGHT, 1'b1, 1'b0, LEFT,  "tv_disable"};

      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst");
      rst = 1'b0;
      ws_run = 1'b1;

      // disable command while already disabled is a no-op
      send_cmd(1'b0, 1'b1, RIGHT, f0);
      @(negedge clk);
      chk("noop_ready", cmd_ready, 1);
      chk("noop_rx_en", rx_en, 0);
      chk("noop_cfg", {rx_cfg_single, rx_cfg_sel}, 0);

      // basic enable
      send_cmd(1'b1, 1'b0, LEFT, f0);
      @(negedge clk);
      chk("en_sync_ready", cmd_ready, 0);
      chk("en_sync_rx_en", rx_en, 0);
      wait_lock(f0, "basic");
      chk("basic_frame0", frame_cnt, 0);
      wait_fall_cnt(16'd1, "basic_frame1");
      wait_fall_cnt(16'd2, "basic_frame2");

      // reconfigure while a word is stuck downstream
      @(posedge clk);
      #1;
      rx_tx_valid = 1'b1;
      send_cmd(1'b1, 1'b1, RIGHT, f0);
      @(negedge clk);
      fc = frame_cnt;
      chk("rc_drain_en", rx_en, 1);
      chk("rc_drain_ready", cmd_ready, 0);
      chk("rc_cfg_hold", {rx_cfg_single, rx_cfg_sel}, 0);
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (ws_falls > f0) ok = 1;
         else @(negedge clk);
      end
      hold = rx_en;
      repeat (5) begin
         @(negedge clk);
         hold = hold & rx_en;
      end
      chk("rc_hold_fall", {ok, hold}, 2'b11);
      @(posedge clk);
      #1;
      rx_tx_ready = 1'b1;
      @(negedge clk);
      f1 = ws_falls;
      chk("rc_hs_cycle", rx_en, 1);
      @(posedge clk);
      #1;
      rx_tx_ready = 1'b0;
      rx_tx_valid = 1'b0;
      @(negedge clk);
      chk("rc_exit_rx_en", rx_en, 0);
      chk("rc_cfg_new", {rx_cfg_single, rx_cfg_sel}, 2'b11);
      chk("rc_sync_ready", cmd_ready, 0);
      chk("rc_frame", frame_cnt, fc + 16'd1);
      wait_lock(f1, "rc");

      // table of run-time commands
      for (int v = 0; v < 4; v++) begin
         send_cmd(tv[v].en, tv[v].single, tv[v].sel, f0);
         wait_en_low(f1, ok);
         chk({tv[v].nm, "_exit"}, ok, 1);
         chk({tv[v].nm, "_ready"}, cmd_ready, tv[v].exp_ready);
         chk({tv[v].nm, "_cfg"}, {rx_cfg_single, rx_cfg_sel},
             {tv[v].exp_single, tv[v].exp_sel});
         if (tv[v].en) wait_lock(f1, tv[v].nm);
      end

      send_cmd(1'b1, 1'b0, LEFT, f0);
      wait_lock(f0, "re");

      // WS loss with a command presented in the timeout cycle
      repeat (3) @(negedge clk);
      ws_run = 1'b0;
      @(negedge clk);
      fc = frame_cnt;
      le = last_edge;
      ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (cyc == le + WT - 1) ok = 1;
         else chk("loss_early", ws_lost, 0);
      end
      chk("loss_wait", ok, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_en = 1'b1;
      cmd_single = 1'b1;
      cmd_sel = LEFT;
      @(negedge clk);
      f0 = ws_falls;
      chk("to_ready", cmd_ready, 0);
      chk("to_rx_en", rx_en, 1);
      @(negedge clk);
      chk("lost_pulse", ws_lost, 1);
      chk("lost_rx_en", rx_en, 0);
      chk("lost_ready", cmd_ready, 0);
      @(negedge clk);
      chk("lost_once", ws_lost, 0);
      ws_run = 1'b1;
      wait_lock(f0, "relock");
      chk("relock_frame", frame_cnt, fc);
      chk("late_ready", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("late_drain", {rx_en, locked}, 2'b10);
      wait_en_low(f1, ok);
      chk("late_exit", ok, 1);
      wait_lock(f1, "late");

      // async reset while draining with a pending enable
      @(posedge clk);
      #1;
      rx_tx_valid = 1'b1;
      send_cmd(1'b1, 1'b0, RIGHT, f0);
      @(negedge clk);
      chk("rs_drain", {rx_en, locked}, 2'b10);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset("rs_async");
      sb_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      rx_tx_valid = 1'b0;
      hold = 1'b1;
      repeat (100) begin
         @(negedge clk);
         hold = hold & ~rx_en & cmd_ready & ~rx_cfg_sel;
      end
      chk("rs_discard", hold, 1);
      chk("sb_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
